// File: rtl/bcd_counter_display.sv
// bcd_counter_display: N-digit BCD up/down counter with wrap limit, tick prescaler and muxed 7-segment drive.
// Define BCD_CNT_BLANK_EN to blank leading zero digits.
module bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                up,
    input  logic                clear,
    input  logic [2:0]          speed,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [PW-1:0] pcnt, period, p_last;
    logic [SW-1:0] scnt;
    logic [IW-1:0] idx;
    logic [3:0]    digit;
    logic          tick, step, hit, blank, scan_end;

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic dn);
        logic       c;
        logic [3:0] d;
        bcd_step = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                bcd_step[4*i +: 4] = dn ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d >= 4'd9 ? 4'd0 : d + 4'd1);
                c = dn ? d == 4'd0 : d >= 4'd9;
            end
        end
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'b1000000;
            4'd1: decode = 7'b1111001;
            4'd2: decode = 7'b0100100;
            4'd3: decode = 7'b0110000;
            4'd4: decode = 7'b0011001;
            4'd5: decode = 7'b0010010;
            4'd6: decode = 7'b0000010;
            4'd7: decode = 7'b1111000;
            4'd8: decode = 7'b0000000;
            4'd9: decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // A shortened period makes pcnt >= p_last immediately, so a speed change can never stall the prescaler.
    assign period   = PW'(TICK_DIV) >> speed;
    assign p_last   = period == '0 ? '0 : period - 1'b1;
    assign tick     = pcnt >= p_last;
    assign step     = tick && run;
    assign hit      = up ? count >= limit : count == '0;
    assign scan_end = scnt == SW'(SCAN_DIV - 1);
    assign digit    = 4'(count >> {idx, 2'b00});
`ifdef BCD_CNT_BLANK_EN
    assign blank = idx != '0 && (count >> {idx, 2'b00}) == '0;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            wrap <= !clear && step && hit;
            if (clear)
                count <= '0;
            else if (step)
                count <= hit ? (up ? '0 : limit) : bcd_step(count, !up);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            idx  <= '0;
            an   <= '1;
            seg  <= 7'h7F;
        end else begin
            scnt <= scan_end ? '0 : scnt + 1'b1;
            if (scan_end)
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            an  <= ~(DIGITS'(1) << idx);
            seg <= blank ? 7'h7F : decode(digit);
        end
    end
endmodule

// File: tb/tb_bcd_counter_display.sv
// tb_bcd_counter_display: vector table, corner sequences and random run against a decimal reference model.
module tb_bcd_counter_display;
    logic        clk = 1'b0, rst, run, up, clear;
    logic [2:0]  speed;
    logic [15:0] limit, count;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;

    bcd_counter_display #(.DIGITS(4), .TICK_DIV(8), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run), .up(up), .clear(clear), .speed(speed),
        .limit(limit), .count(count), .wrap(wrap), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    int mpc, msc, midx;
    logic [15:0] mcnt;
    logic        mw;
    logic [3:0]  man, mprev;
    logic [6:0]  mseg;

    typedef struct {
        logic        run, up, clr;
        logic [2:0]  spd;
        logic [15:0] lim;
        int          n;
        logic [15:0] cnt;
        int          wraps;
    } vec_t;
    vec_t vecs[12];

    function automatic int to_dec(logic [15:0] v);
        int r = 0, m = 1;
        for (int i = 0; i < 4; i++) begin
            r += int'(v[4*i +: 4]) * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n /= 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(logic [15:0] v, int i);
        logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        logic [15:0] hi = v >> (4 * i);
        logic [3:0]  d = hi[3:0];
`ifdef BCD_CNT_BLANK_EN
        if (i > 0 && hi == 16'h0) return 7'h7F;
`endif
        return d > 4'd9 ? 7'h3F : pat[d];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mpc = 0; msc = 0; midx = 0; mcnt = 16'h0; mw = 1'b0; man = 4'hF; mprev = 4'hF; mseg = 7'h7F;
    endtask

    task automatic model_edge();
        int p = 8 >> speed;
        logic tk;
        if (p < 1) p = 1;
        tk = mpc >= p - 1;
        mprev = man;
        man = 4'hF ^ 4'(1 << midx);
        mseg = seg_of(mcnt, midx);
        if (msc == 3) begin
            msc = 0;
            midx = (midx + 1) % 4;
        end else msc++;
        mpc = tk ? 0 : mpc + 1;
        mw = 1'b0;
        if (clear) mcnt = 16'h0;
        else if (tk && run) begin
            if (up) begin
                if (mcnt >= limit) begin mcnt = 16'h0; mw = 1'b1; end
                else mcnt = to_bcd(to_dec(mcnt) + 1);
            end else begin
                if (mcnt == 16'h0) begin mcnt = limit; mw = 1'b1; end
                else mcnt = to_bcd(to_dec(mcnt) - 1);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("count", count, mcnt);
        check("wrap", wrap, mw);
        check("an", an, man);
        check("seg", seg, mseg);
    endtask

    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_exp [4];

    initial begin
        int nw;
        bit ok;
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 16'h9999, 80,  16'h0010, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h9999, 89,  16'h0099, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h9999, 1,   16'h0100, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h0100, 1,   16'h0000, 1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd3, 16'h0100, 3,   16'h0000, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd3, 16'h0250, 1,   16'h0250, 1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd3, 16'h0250, 2,   16'h0248, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'd3, 16'h9999, 1,   16'h0000, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h9999, 123, 16'h0123, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'd3, 16'h9999, 1,   16'h0000, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h9999, 5,   16'h0005, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h9999, 40,  16'h0005, 0};
`ifdef BCD_CNT_BLANK_EN
        seg_exp = '{7'h24, 7'h19, 7'h7F, 7'h7F};
`else
        seg_exp = '{7'h24, 7'h19, 7'h40, 7'h40};
`endif
        rst = 1'b1; run = 1'b0; up = 1'b1; clear = 1'b0; speed = 3'd0; limit = 16'h9999;
        model_reset();
        #12;
        check("reset count", count, 16'h0);
        check("reset wrap", wrap, 1'b0);
        check("reset an", an, 4'hF);
        check("reset seg", seg, 7'h7F);
        rst = 1'b0;

        for (int r = 0; r < 12; r++) begin
            run = vecs[r].run; up = vecs[r].up; clear = vecs[r].clr;
            speed = vecs[r].spd; limit = vecs[r].lim;
            nw = 0;
            for (int c = 0; c < vecs[r].n; c++) begin
                step();
                nw += int'(wrap);
            end
            check($sformatf("row%0d count", r), count, vecs[r].cnt);
            check($sformatf("row%0d wraps", r), nw, vecs[r].wraps);
        end
        clear = 1'b0;

        run = 1'b0; speed = 3'd0;
        for (int i = 0; i < 16 && mpc != 6; i++) step();
        check("pcnt sync reached", mpc, 6);
        speed = 3'd3; run = 1'b1; up = 1'b1; limit = 16'h9999;
        step(); check("speed tick next", count, 16'h0006);
        step(); check("speed tick every", count, 16'h0007);
        limit = 16'h0005;
        step(); check("above limit count", count, 16'h0000);
        check("above limit wrap", wrap, 1'b1);

        up = 1'b0; limit = 16'h00A0;
        step(); check("hex limit load", count, 16'h00A0);
        check("hex limit wrap", wrap, 1'b1);
        step(); check("hex digit dec", count, 16'h0099);

        run = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst count", count, 16'h0);
        check("async rst an", an, 4'hF);
        check("async rst seg", seg, 7'h7F);
        model_reset();
        #1 rst = 1'b0;

        run = 1'b1; up = 1'b1; speed = 3'd3; limit = 16'h9999;
        repeat (42) step();
        check("preload 42", count, 16'h0042);
        run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            step();
            ok = mprev == 4'b0111 && man == 4'b1110;
        end
        check("scan sync reached", ok, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            check($sformatf("scan an %0d", k), an, an_exp[k/4]);
            check($sformatf("scan seg %0d", k), seg, seg_exp[k/4]);
        end

        for (int i = 0; i < 400; i++) begin
            run = $urandom % 4 != 0;
            up = 1'($urandom % 2);
            clear = $urandom % 40 == 0;
            if (i % 16 == 0) speed = 3'($urandom % 8);
            if (i % 60 == 0) limit = to_bcd(int'($urandom % 10000));
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

Parametrised, fully synchronous N-digit BCD up/down counter with programmable wrap limit, rate prescaler and multiplexed active-low 7-segment driver. It replaces the fixed 4-digit ripple-clocked counter/display pair on the board top level. All state runs on `clk`, and the block generates no derived clocks. It sits between the switch/button inputs and the `an`/`seg` pins.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits and display anodes (1–8).
- `TICK_DIV`, 50000000: count-tick period in `clk` cycles at `speed`=0.
- `SCAN_DIV`, 100000: display digit dwell time in `clk` cycles.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high. Clock is `clk`.
- `run`  in  1: 1 = counting enabled; 0 = hold the value (the prescaler keeps running).
- `up`  in  1: 1 = increment, 0 = decrement.
- `clear`  in  1: synchronous clear to 0.
- `speed`  in  3: tick period = `TICK_DIV >> speed`, minimum 1.
- `limit`  in  4*DIGITS: BCD terminal value for wrap.
- `count`  out  4*DIGITS: current BCD value, registered.
- `wrap`  out  1: one-cycle pulse on every wrap (either direction).
- `an`  out  DIGITS: active-low one-hot anode select.
- `seg`  out  7: active-low segments, bit order gfedcba.

## Operation
- Prescaler: `pcnt` counts 0..P-1, where P = max(1, `TICK_DIV >> speed`). `tick` is asserted for the cycle where `pcnt` >= P-1, and `pcnt` returns to 0 on that cycle. A `speed` change that shortens P below the current `pcnt` causes a tick on the next cycle. No lock-up is allowed.
- Counter update on a `tick` cycle with `run`=1:
  - Up, `count` == `limit`: next value is 0 and `wrap` pulses.
  - Up, `count` > `limit` (binary compare of the BCD vectors): next value is 0 and `wrap` pulses.
  - Up, otherwise: BCD increment. A digit at 9 becomes 0 and carries into the next digit in the same cycle.
  - Down, `count` == 0: next value is `limit` and `wrap` pulses.
  - Down, otherwise: BCD decrement with borrow. A digit at 0 becomes 9.
- Non-BCD digits in `limit` (A–F) are not rejected. The compare uses the raw value, and the block can never produce a digit >9 by incrementing.
- Priority order: `rst` > `clear` > tick update > hold. `clear` forces `count`=0, does not pulse `wrap`, and does not reset the prescaler.
- Display scan:
  - `scnt` counts 0..SCAN_DIV-1. On wrap, `idx` advances 0→DIGITS-1→0.
  - `an` drives low only bit `idx`.
  - `seg` decodes digit `idx` of `count`: 0–9 use the standard patterns (0=1000000, 1=1111001, 8=0000000, 9=0010000), and A–F decode to 0111111 (dash).

## Timing
- Reset values: `count`=0, `wrap`=0, `pcnt`=0, `scnt`=0, `idx`=0, `an`=all 1s, `seg`=1111111. After `rst` deasserts, the first `an`/`seg` update occurs at the first clock edge.
- Tick to `count` latency: `count` changes on the clock edge that ends the tick cycle. `wrap` is registered and asserted in the same cycle as the new `count`.
- `an` and `seg` are registered together and change on the same edge, one cycle after `idx`. A `count` change appears on `seg` within 1 cycle when that digit is selected.
- With `run`=0 there are no `count` changes and no `wrap`. A tick that occurs while `run`=0 is lost, not queued.
- Asserting `rst` mid-count zeroes all state immediately and asynchronously.

## Configuration
- `BCD_CNT_BLANK_EN` defined: leading-zero blanking.
  - Any digit position above the most-significant non-zero digit drives `seg`=1111111. Its anode still scans.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: all digits are always decoded, including leading zeros.

## Test plan
Use DIGITS=4, TICK_DIV=8, SCAN_DIV=4 for all scenarios.
- Reset then `run`=1, `up`=1, `speed`=0, `limit`=9999 for 80 cycles: expect `count`=0010, one tick every 8 cycles, `wrap`=0.
- Preload to 0099 via counting with `speed`=3 (P=1): the next tick gives 0100 with carries in one cycle. `limit`=0100, up: the next tick gives 0000 and `wrap` is high for exactly 1 cycle.
- Down from 0000 with `limit`=0250: next is 0250 with a `wrap` pulse. Next is 0249, then 0248.
- `clear` asserted on a tick cycle at 0123: expect `count`=0000 and no `wrap`. Check `run`=0 for 40 cycles: `count` stays constant.
- `speed` 0→3 while `pcnt`=6: expect a tick on the next cycle, then one every cycle. Then `limit` set to 0005 while `count`=0007, up: next tick gives 0000 with `wrap`.
- Scan with `count`=0042: `an` sequence 1110, 1101, 1011, 0111, each held 4 cycles. `seg` shows 2, 4, 0, 0. With `BCD_CNT_BLANK_EN`, digits 2–3 show 1111111.
